conv_layer_scheduler: RTL and testbench
=======================================

CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 Parameter IMG, 8, input tile side length (tile is IMG x IMG bytes).
REQ-002 Parameter K, 3, filter side length; output side OUT = IMG-K+1 (6 at defaults).
REQ-003 Parameter NFILT, 3, number of filters to sweep (max 4).
REQ-004 Parameter PIPE_LAT, 1, cycles from window issue to datapath result valid (min 1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one full layer pass; sampled only in IDLE.
REQ-008 stall  input  1  downstream backpressure; freezes compute progress.
REQ-009 rd_addr  output  6  input-memory read address, row-major {row[5:3], col[2:0]}.
REQ-010 ld_we  output  1  tensor-register write strobe for read data returned this cycle.
REQ-011 ld_addr  output  6  tensor-register index for ld_we (rd_addr delayed 1 cycle).
REQ-012 win_row  output  3  top row of the current 3x3 window.
REQ-013 win_col  output  3  left column of the current 3x3 window.
REQ-014 filt_sel  output  2  filter/bias select for the current window.
REQ-015 wr_en  output  1  result-memory write enable.
REQ-016 wr_addr  output  8  result address {filt[1:0], pos[5:0]}, pos = row*OUT+col.
REQ-017 busy  output  1  high in LOAD, DRAIN, COMPUTE, FLUSH.
REQ-018 done  output  1  one-cycle pulse in DONE.

Function
REQ-019 States SHALL be IDLE, LOAD, DRAIN, COMPUTE, FLUSH, DONE.
REQ-020 IDLE -> LOAD when start=1; start in any other state SHALL be ignored.
REQ-021 LOAD: rd_addr SHALL be 0 in the first LOAD cycle and increment by 1 per cycle up to IMG*IMG-1, then -> DRAIN.
REQ-022 ld_we SHALL be 1 exactly one cycle after each rd_addr issue, with ld_addr = that rd_addr (1-cycle memory read latency); 64 strobes per pass, the last in DRAIN.
REQ-023 DRAIN lasts exactly 1 cycle, then -> COMPUTE.
REQ-024 COMPUTE: filt_sel outer (0..NFILT-1), win_row middle (0..OUT-1), win_col inner (0..OUT-1); one window issued per non-stalled cycle; 108 windows at defaults.
REQ-025 stall=1 in COMPUTE or FLUSH SHALL hold counters, state, and write-delay line; wr_en SHALL be 0 during stall cycles.
REQ-026 wr_en/wr_addr SHALL be the issued window's {filt_sel, pos} delayed by PIPE_LAT non-stalled cycles; exactly one write per window, no duplicates.
REQ-027 After the last window (filt=NFILT-1, row=col=OUT-1) -> FLUSH for PIPE_LAT non-stalled cycles, then -> DONE.
REQ-028 DONE lasts 1 cycle (done=1, busy=0), then -> IDLE.
REQ-029 pos SHALL be computed without overflow in 6 bits; win counters SHALL wrap col->row->filt and never exceed OUT-1.
REQ-030 Outside their active states, rd_addr, ld_addr, win_row, win_col, filt_sel, wr_addr SHALL be 0 and ld_we, wr_en 0.

Reset
REQ-031 reset=1 at any edge, including mid-pass, SHALL force IDLE, zero all counters and delay line, and drive every output to 0 on the next cycle; no further writes from the aborted pass.
REQ-032 reset has priority over start and stall.

Verification
REQ-033 start pulse at cycle 0, stall=0, defaults -> LOAD cycles 1..64 (rd_addr 0..63), DRAIN 65, COMPUTE 66..173, first wr_en at 67 with wr_addr 0x00, last at 174 with wr_addr 0x A3 (filt 2, pos 35), done=1 at 175.
REQ-034 Check ld_we: 64 strobes, cycles 2..65, ld_addr 0..63 in order, each equal to rd_addr of the prior cycle.
REQ-035 stall=1 for 5 cycles at cycle 100 -> counters frozen, wr_en=0 for those cycles, done delayed to 180, all 108 addresses written exactly once.
REQ-036 reset=1 at cycle 120 mid-COMPUTE -> next cycle all outputs 0, busy=0; new start then yields a full correct pass.
REQ-037 start held high throughout pass -> ignored while busy; second pass starts the cycle after DONE (IDLE sampled).
REQ-038 PIPE_LAT=3 -> wr_en lags window issue by 3 cycles, FLUSH 3 cycles, done at 177.

Source files
------------

// File: rtl/conv_layer_scheduler_if.sv
// Control/status bundle between the convolution layer scheduler and the
// surrounding datapath: start/stall in, memory and window controls out.
interface conv_layer_scheduler_if;
    logic       start;
    logic       stall;
    logic [5:0] rd_addr;
    logic       ld_we;
    logic [5:0] ld_addr;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic [1:0] filt_sel;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic       busy;
    logic       done;

    // Scheduler side
    modport slave (
        input  start, stall,
        output rd_addr, ld_we, ld_addr, win_row, win_col, filt_sel,
               wr_en, wr_addr, busy, done
    );

    // Controller / datapath side
    modport master (
        output start, stall,
        input  rd_addr, ld_we, ld_addr, win_row, win_col, filt_sel,
               wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Convolution layer scheduler: loads one IMG x IMG tile into the tensor
// registers, then sweeps every KxK window for each filter and sequences the
// result-memory writes behind a PIPE_LAT-deep datapath.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | issuing input-memory reads 0..IMG*IMG-1
// DRAIN   | last read data returning (final ld_we)
// COMPUTE | issuing one window per non-stalled cycle
// FLUSH   | letting the last PIPE_LAT results drain to memory
// DONE    | one-cycle completion pulse
module conv_layer_scheduler #(
    parameter int IMG      = 8,
    parameter int K        = 3,
    parameter int NFILT    = 3,
    parameter int PIPE_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_layer_scheduler_if.slave   bus
);

    localparam int         OUT        = IMG - K + 1;
    localparam logic [5:0] LAST_RD    = 6'(IMG * IMG - 1);
    localparam logic [2:0] LAST_RC    = 3'(OUT - 1);
    localparam logic [1:0] LAST_F     = 2'(NFILT - 1);
    localparam logic [7:0] FLUSH_INIT = 8'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_COMPUTE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t     state;
    logic [5:0] rd_addr_q;
    logic       ld_we_q;
    logic [5:0] ld_addr_q;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [1:0] filt_q;
    logic [7:0] flush_cnt;

    // Results in flight through the datapath; index PIPE_LAT-1 is the one
    // due at the result memory this cycle.
    logic       dl_vld  [PIPE_LAT];
    logic [7:0] dl_addr [PIPE_LAT];

    logic [5:0] pos;
    logic       advance;
    logic       last_win;

    // Window position, progress enable and end-of-sweep detect
    always_comb begin
        pos      = 6'(row_q) * 6'(OUT) + 6'(col_q);
        advance  = ((state == S_COMPUTE) || (state == S_FLUSH)) && !bus.stall;
        last_win = (filt_q == LAST_F) && (row_q == LAST_RC) && (col_q == LAST_RC);
    end

    // Sequencing FSM with its address/window counters and load strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_addr_q <= '0;
            ld_we_q   <= 1'b0;
            ld_addr_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            filt_q    <= '0;
            flush_cnt <= '0;
        end else begin
            // Read data comes back one cycle after each LOAD issue
            ld_we_q   <= (state == S_LOAD);
            ld_addr_q <= (state == S_LOAD) ? rd_addr_q : '0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_LOAD;
                        rd_addr_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (rd_addr_q == LAST_RD) begin
                        state     <= S_DRAIN;
                        rd_addr_q <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + 6'd1;
                    end
                end
                S_DRAIN: begin
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (!bus.stall) begin
                        if (last_win) begin
                            state     <= S_FLUSH;
                            row_q     <= '0;
                            col_q     <= '0;
                            filt_q    <= '0;
                            flush_cnt <= FLUSH_INIT;
                        end else if (col_q == LAST_RC) begin
                            col_q <= '0;
                            if (row_q == LAST_RC) begin
                                row_q  <= '0;
                                filt_q <= filt_q + 2'd1;
                            end else begin
                                row_q <= row_q + 3'd1;
                            end
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!bus.stall) begin
                        if (flush_cnt == 8'd0) begin
                            state <= S_DONE;
                        end else begin
                            flush_cnt <= flush_cnt - 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write-delay line: shifts only on non-stalled compute/flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_vld[i]  <= 1'b0;
                dl_addr[i] <= '0;
            end
        end else if (advance) begin
            dl_vld[0]  <= (state == S_COMPUTE);
            dl_addr[0] <= (state == S_COMPUTE) ? {filt_q, pos} : 8'd0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    // A result waiting at the tail is held back while stalled
    assign bus.wr_en    = dl_vld[PIPE_LAT-1] & ~bus.stall;
    assign bus.wr_addr  = bus.wr_en ? dl_addr[PIPE_LAT-1] : 8'd0;

    assign bus.rd_addr  = rd_addr_q;
    assign bus.ld_we    = ld_we_q;
    assign bus.ld_addr  = ld_addr_q;
    assign bus.win_row  = row_q;
    assign bus.win_col  = col_q;
    assign bus.filt_sel = filt_q;
    assign bus.busy     = (state == S_LOAD) || (state == S_DRAIN) ||
                          (state == S_COMPUTE) || (state == S_FLUSH);
    assign bus.done     = (state == S_DONE);

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: two instances (PIPE_LAT 1 and 3) run the
// same directed and randomly stalled scenarios; per-cycle expectations come
// from a pass-level model built on the list of non-stalled compute cycles.
module tb_conv_layer_scheduler;

    localparam int NPIX = 64;
    localparam int OUT  = 6;
    localparam int NF   = 3;
    localparam int NWIN = NF * OUT * OUT;
    localparam int MAXC = 1024;
    localparam int BIG  = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_layer_scheduler_if b0 ();
    conv_layer_scheduler_if b1 ();

    conv_layer_scheduler #(.PIPE_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    conv_layer_scheduler #(.PIPE_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int tests = 0;
    int fails = 0;
    int lat_of [2] = '{1, 3};

    bit         stall_at [MAXC];
    bit         start_at [2][MAXC];
    int         rst_cyc;

    logic       e_busy  [2][MAXC];
    logic       e_done  [2][MAXC];
    logic [5:0] e_rd    [2][MAXC];
    logic       e_ldwe  [2][MAXC];
    logic [5:0] e_ldadr [2][MAXC];
    logic [2:0] e_row   [2][MAXC];
    logic [2:0] e_col   [2][MAXC];
    logic [1:0] e_filt  [2][MAXC];
    logic       e_wren  [2][MAXC];
    logic [7:0] e_wradr [2][MAXC];

    task automatic clear_seg();
        rst_cyc = -1;
        for (int c = 0; c < MAXC; c++) begin
            stall_at[c] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                start_at[d][c] = 1'b0;
                e_busy[d][c]   = 1'b0;
                e_done[d][c]   = 1'b0;
                e_rd[d][c]     = '0;
                e_ldwe[d][c]   = 1'b0;
                e_ldadr[d][c]  = '0;
                e_row[d][c]    = '0;
                e_col[d][c]    = '0;
                e_filt[d][c]   = '0;
                e_wren[d][c]   = 1'b0;
                e_wradr[d][c]  = '0;
            end
        end
    endtask

    // One layer pass whose start is sampled at the end of cycle c0; nothing
    // after cycle lim belongs to this pass (reset aborts it).
    task automatic model_pass(input int d, input int c0, input int lim, output int done_c);
        int lat = lat_of[d];
        int cs  = c0 + NPIX + 2;
        int ns[$];
        int t;
        int w;
        for (int i = 0; i < NPIX; i++) begin
            t = c0 + 1 + i;
            if (t <= lim && t < MAXC) e_rd[d][t] = 6'(i);
            t = c0 + 2 + i;
            if (t <= lim && t < MAXC) begin
                e_ldwe[d][t]  = 1'b1;
                e_ldadr[d][t] = 6'(i);
            end
        end
        for (t = c0 + 1; t < cs; t++)
            if (t <= lim && t < MAXC) e_busy[d][t] = 1'b1;
        t = cs;
        while (ns.size() < NWIN + lat && t < MAXC) begin
            if (!stall_at[t]) ns.push_back(t);
            t++;
        end
        w = 0;
        for (t = cs; t <= ns[NWIN-1]; t++) begin
            if (t <= lim && t < MAXC) begin
                e_busy[d][t] = 1'b1;
                e_filt[d][t] = 2'(w / (OUT * OUT));
                e_row[d][t]  = 3'((w % (OUT * OUT)) / OUT);
                e_col[d][t]  = 3'(w % OUT);
            end
            if (!stall_at[t]) w++;
        end
        for (t = ns[NWIN-1] + 1; t <= ns[NWIN+lat-1]; t++)
            if (t <= lim && t < MAXC) e_busy[d][t] = 1'b1;
        for (int k = 0; k < NWIN; k++) begin
            t = ns[k + lat];
            if (t <= lim && t < MAXC) begin
                e_wren[d][t]  = 1'b1;
                e_wradr[d][t] = {2'(k / (OUT * OUT)), 6'(k % (OUT * OUT))};
            end
        end
        done_c = ns[NWIN+lat-1] + 1;
        if (done_c <= lim && done_c < MAXC) e_done[d][done_c] = 1'b1;
    endtask

    task automatic chk(input int d, input string name, input int c,
                       input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL d%0d.%s cycle %0d: observed %0h expected %0h", d, name, c, got, exp);
        end
    endtask

    task automatic check_cycle(input int d, input int c,
                               input logic busy, input logic done,
                               input logic [5:0] rd, input logic ldwe, input logic [5:0] ldadr,
                               input logic [2:0] row, input logic [2:0] col, input logic [1:0] filt,
                               input logic wren, input logic [7:0] wradr);
        chk(d, "busy",     c, 8'(busy),  8'(e_busy[d][c]));
        chk(d, "done",     c, 8'(done),  8'(e_done[d][c]));
        chk(d, "rd_addr",  c, 8'(rd),    8'(e_rd[d][c]));
        chk(d, "ld_we",    c, 8'(ldwe),  8'(e_ldwe[d][c]));
        chk(d, "ld_addr",  c, 8'(ldadr), 8'(e_ldadr[d][c]));
        chk(d, "win_row",  c, 8'(row),   8'(e_row[d][c]));
        chk(d, "win_col",  c, 8'(col),   8'(e_col[d][c]));
        chk(d, "filt_sel", c, 8'(filt),  8'(e_filt[d][c]));
        chk(d, "wr_en",    c, 8'(wren),  8'(e_wren[d][c]));
        chk(d, "wr_addr",  c, wradr,     e_wradr[d][c]);
    endtask

    // Entered #1 after a rising edge; leaves the DUTs idle after reset.
    task automatic seg_reset();
        reset    = 1'b1;
        b0.start = 1'b0;
        b1.start = 1'b0;
        b0.stall = 1'b0;
        b1.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_seg(input int len);
        for (int c = 0; c < len; c++) begin
            reset    = (c == rst_cyc);
            b0.start = start_at[0][c];
            b1.start = start_at[1][c];
            b0.stall = stall_at[c];
            b1.stall = stall_at[c];
            @(negedge clk);
            check_cycle(0, c, b0.busy, b0.done, b0.rd_addr, b0.ld_we, b0.ld_addr,
                        b0.win_row, b0.win_col, b0.filt_sel, b0.wr_en, b0.wr_addr);
            check_cycle(1, c, b1.busy, b1.done, b1.rd_addr, b1.ld_we, b1.ld_addr,
                        b1.win_row, b1.win_col, b1.filt_sel, b1.wr_en, b1.wr_addr);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int dc [2];
        int dc2 [2];
        int len;

        b0.start = 1'b0;
        b1.start = 1'b0;
        b0.stall = 1'b0;
        b1.stall = 1'b0;
        @(posedge clk);
        #1;

        // Plain pass, start pulse at cycle 0
        clear_seg();
        seg_reset();
        start_at[0][0] = 1'b1;
        start_at[1][0] = 1'b1;
        for (int d = 0; d < 2; d++) model_pass(d, 0, BIG, dc[d]);
        run_seg(dc[1] + 4);

        // Five stall cycles starting at cycle 100
        clear_seg();
        seg_reset();
        for (int c = 100; c < 105; c++) stall_at[c] = 1'b1;
        start_at[0][0] = 1'b1;
        start_at[1][0] = 1'b1;
        for (int d = 0; d < 2; d++) model_pass(d, 0, BIG, dc[d]);
        run_seg(dc[1] + 4);

        // Random backpressure throughout the pass
        clear_seg();
        seg_reset();
        for (int c = 0; c < MAXC; c++) stall_at[c] = ($urandom_range(0, 3) == 0);
        start_at[0][0] = 1'b1;
        start_at[1][0] = 1'b1;
        for (int d = 0; d < 2; d++) model_pass(d, 0, BIG, dc[d]);
        len = (dc[0] > dc[1]) ? dc[0] : dc[1];
        run_seg(len + 4);

        // Reset mid-COMPUTE at cycle 120, then a fresh pass from cycle 125
        clear_seg();
        seg_reset();
        rst_cyc = 120;
        start_at[0][0]   = 1'b1;
        start_at[1][0]   = 1'b1;
        start_at[0][125] = 1'b1;
        start_at[1][125] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_pass(d, 0, 120, dc[d]);
            model_pass(d, 125, BIG, dc2[d]);
        end
        run_seg(dc2[1] + 4);

        // start held high: ignored while busy, second pass right after DONE
        clear_seg();
        seg_reset();
        for (int d = 0; d < 2; d++) begin
            model_pass(d, 0, BIG, dc[d]);
            for (int c = 0; c <= dc[d] + 1; c++) start_at[d][c] = 1'b1;
            model_pass(d, dc[d] + 1, BIG, dc2[d]);
        end
        run_seg(dc2[1] + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
